grant_dec: RTL and testbench
============================

Name: grant_dec

Overview:
Sequential grant issuer. It is the other end of the priority-encoder interface: it takes a binary grant index plus valid and drives a one-hot grant back to the requesters. The grant is held until the granted requester signals done or a hold timeout expires. It sits between the arbitration encoder output and the N requester ports.

Parameters:
N, 4, number of requesters (any value >= 2; power of two not required)
MAX_HOLD, 16, maximum grant cycles before forced release; 0 disables the timeout
IDX_W (localparam), $clog2(N), index width
CNT_W (localparam), $clog2(MAX_HOLD+1), hold counter width (minimum 1)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  reset, synchronous and active-high
idx_in  input  IDX_W  binary index of the winning requester
idx_valid  input  1  idx_in is valid this cycle
idx_ready  output  1  block can accept an index this cycle
done  input  N  per-requester release; only the bit of the current grantee is honoured
gnt_oh  output  N  registered one-hot grant; all zero when no grant is active
busy  output  1  grant active or release gap in progress
timeout  output  1  one-cycle pulse: the last grant ended by timeout
err_idx  output  1  one-cycle pulse: an index >= N was offered and dropped

Behaviour:
- Reset (rst=1 at a clock edge), effective next cycle: state=IDLE, gnt_oh=0, busy=0, timeout=0, err_idx=0, hold counter=0, idx_ready=1. Reset overrides everything, including mid-grant: gnt_oh drops to 0 the cycle after rst is sampled.
- States: IDLE, GRANT, GAP (encoded in a 2-bit enum).
- IDLE:
  - idx_ready=1 (combinational from state).
  - Accept occurs when idx_valid and idx_ready are both 1.
  - Legal accept (idx_in < N): latch idx_q, go to GRANT. gnt_oh = 1<<idx_q from the next cycle, so grant latency is 1 cycle.
  - Illegal index (idx_in >= N): err_idx pulses the next cycle, no grant, state stays IDLE.
- GRANT:
  - idx_ready=0, busy=1, gnt_oh one-hot at idx_q.
  - The counter starts at 0 on the first GRANT cycle and increments each GRANT cycle.
  - Release when done[idx_q]=1, or when MAX_HOLD != 0 and counter == MAX_HOLD-1. The grant is then visible exactly MAX_HOLD cycles.
  - Either release cause: next state GAP, gnt_oh=0 next cycle.
  - done bits other than idx_q are ignored.
  - If done and the timeout hit occur in the same cycle, done wins and timeout is not pulsed.
  - idx_valid is ignored (not accepted) while in GRANT.
- GAP:
  - Exactly one cycle: gnt_oh=0, busy=1, idx_ready=0.
  - timeout=1 during this cycle only if the release cause was timeout.
  - Counter clears. Next state IDLE.
- Throughput: minimum 3 cycles per grant (accept, grant, gap). Grants never overlap, and gnt_oh is never more than one-hot.
- The counter saturates; it never wraps, even if MAX_HOLD=0 (it is held at 0 when disabled).
- All outputs are registered except idx_ready.

Decomposition:
- Package grant_pkg:
  - typedef enum logic [1:0] {IDLE, GRANT, GAP} grant_state_t
  - function onehot(idx, N) used for gnt_oh generation
- Sub-module hold_timer (parameters MAX_HOLD and CNT_W; ports clk, rst, clear, en, expired). It owns the counter and its saturation. The rest of grant_dec is the FSM plus output registers.

Test Plan:
- Reset: assert rst 3 cycles mid-random-stimulus -> the following cycle gnt_oh=0000, busy=0, timeout=0, err_idx=0, idx_ready=1.
- Normal grant: N=4, idx_in=2 with idx_valid at cycle T -> gnt_oh=0100 at T+1. done[2]=1 at T+5 -> gnt_oh=0000 and busy=1 at T+6, idx_ready=1 at T+7, timeout never 1.
- Timeout: MAX_HOLD=16, idx_in=1, done held 0 -> gnt_oh=0010 for exactly 16 cycles, then timeout=1 for 1 cycle with gnt_oh=0000. Repeat with done[1] asserted on cycle 16 -> timeout stays 0.
- Wrong done / illegal index:
  - During grant to index 3, pulse done=0001 -> grant stays 1000.
  - With N=5, offer idx_in=7 -> err_idx=1 for one cycle, gnt_oh stays 0, next legal idx_in=4 accepted.
- Back-to-back: idx_valid held 1 with indices 0,1,2,3 and done mirroring gnt_oh -> grants issued every 3 cycles in order 0001,0010,0100,1000, never two bits set.
- Reset mid-grant: rst at 4th GRANT cycle of idx 0 -> gnt_oh=0000 next cycle, counter cleared. A new accept afterwards gets a full MAX_HOLD hold.

Source files
------------

// File: rtl/grant_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grant_pkg
// Brief    : Shared state encoding and one-hot helper for the grant issuer.
// Revision : 1.0
// ============================================================================
package grant_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } grant_state_t;

  localparam int unsigned c_MAX_N = 64;

  // Indices outside 0..n-1 produce an all-zero vector rather than a stray bit.
  function automatic logic [c_MAX_N-1:0] onehot(input int unsigned idx,
                                                input int unsigned n);
    logic [c_MAX_N-1:0] v;
    v = '0;
    if (idx < n) v = c_MAX_N'(1) << idx;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// ============================================================================
// Module   : hold_timer
// Brief    : Saturating grant-hold counter; flags the last permitted cycle.
// Revision : 1.0
// ============================================================================
module hold_timer #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] c_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [CNT_W-1:0] c_SAT  = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD)     : '0;

  logic [CNT_W-1:0] r_cnt;

  // With the timeout disabled the counter is pinned at zero.
  always_ff @(posedge clk) begin
    if (rst || clear || (MAX_HOLD == 0)) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != c_SAT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (MAX_HOLD != 0) && en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/grant_dec.sv
`default_nettype none
// ============================================================================
// Module   : grant_dec
// Brief    : Turns an accepted binary grant index into a held one-hot grant,
//            released on the grantee's done or on hold timeout.
// Revision : 1.0
// ============================================================================
module grant_dec
  import grant_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [$clog2(N)-1:0] idx_in,
  input  logic                 idx_valid,
  output logic                 idx_ready,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         gnt_oh,
  output logic                 busy,
  output logic                 timeout,
  output logic                 err_idx
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [IDX_W:0] c_N = (IDX_W + 1)'(N);

  grant_state_t     r_state;
  logic [IDX_W-1:0] r_idx;
  logic [N-1:0]     r_gnt;
  logic             r_busy;
  logic             r_timeout;
  logic             r_err;

  logic             w_legal;
  logic [N-1:0]     w_oh;
  logic             w_done;
  logic             w_expired;

  assign w_legal = ({1'b0, idx_in} < c_N);
  assign w_oh    = N'(onehot(32'(idx_in), N));
  assign w_done  = done[r_idx];

  hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state == GAP),
    .en      (r_state == GRANT),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (idx_valid) begin
            if (w_legal) begin
              r_idx   <= idx_in;
              r_gnt   <= w_oh;
              r_busy  <= 1'b1;
              r_state <= GRANT;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        GRANT: begin
          // done takes precedence, so a coincident expiry is not reported.
          if (w_done || w_expired) begin
            r_gnt     <= '0;
            r_timeout <= ~w_done;
            r_state   <= GAP;
          end
        end
        GAP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign idx_ready = (r_state == IDLE);
  assign gnt_oh    = r_gnt;
  assign busy      = r_busy;
  assign timeout   = r_timeout;
  assign err_idx   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_grant_dec.sv
`default_nettype none
// ============================================================================
// Module   : tb_grant_dec
// Brief    : Directed self-checking bench for grant_dec (N=4 and N=5 builds).
// Revision : 1.0
// ============================================================================
module tb_grant_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] idx_in;
  logic       idx_valid;
  logic [3:0] done;
  logic       idx_ready;
  logic [3:0] gnt_oh;
  logic       busy;
  logic       timeout;
  logic       err_idx;

  logic [2:0] idx_in5;
  logic       idx_valid5;
  logic [4:0] done5;
  logic       idx_ready5;
  logic [4:0] gnt_oh5;
  logic       busy5;
  logic       timeout5;
  logic       err_idx5;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  grant_dec #(.N(4), .MAX_HOLD(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .idx_in    (idx_in),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .done      (done),
    .gnt_oh    (gnt_oh),
    .busy      (busy),
    .timeout   (timeout),
    .err_idx   (err_idx)
  );

  grant_dec #(.N(5), .MAX_HOLD(16)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .idx_in    (idx_in5),
    .idx_valid (idx_valid5),
    .idx_ready (idx_ready5),
    .done      (done5),
    .gnt_oh    (gnt_oh5),
    .busy      (busy5),
    .timeout   (timeout5),
    .err_idx   (err_idx5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Count consecutive samples showing the given grant, bounded.
  task automatic count_grant(input logic [3:0] g, output int n);
    n = 0;
    while ((gnt_oh == g) && (n < 40)) begin
      n++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; idx_in = '0; idx_valid = 1'b0; done = '0;
    idx_in5 = '0; idx_valid5 = 1'b0; done5 = '0;
    tick(); tick();
    chk("rst_gnt", 32'(gnt_oh), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(idx_ready), 32'h1);
    rst = 1'b0;
    tick();

    // Normal grant released by done
    idx_in = 2'd2; idx_valid = 1'b1;
    tick();
    idx_valid = 1'b0;
    chk("norm_gnt", 32'(gnt_oh), 32'h4);
    chk("norm_busy", 32'(busy), 32'h1);
    chk("norm_ready", 32'(idx_ready), 32'h0);
    tick(); tick(); tick();
    chk("norm_hold", 32'(gnt_oh), 32'h4);
    done = 4'b0100;
    tick();
    done = '0;
    chk("norm_gap_gnt", 32'(gnt_oh), 32'h0);
    chk("norm_gap_busy", 32'(busy), 32'h1);
    chk("norm_gap_ready", 32'(idx_ready), 32'h0);
    chk("norm_gap_to", 32'(timeout), 32'h0);
    tick();
    chk("norm_idle_ready", 32'(idx_ready), 32'h1);
    chk("norm_idle_busy", 32'(busy), 32'h0);

    // Timeout after exactly 16 grant cycles
    idx_in = 2'd1; idx_valid = 1'b1;
    tick();
    idx_valid = 1'b0;
    count_grant(4'b0010, cyc);
    chk("to_len", 32'(cyc), 32'd16);
    chk("to_gnt", 32'(gnt_oh), 32'h0);
    chk("to_pulse", 32'(timeout), 32'h1);
    tick();
    chk("to_pulse_end", 32'(timeout), 32'h0);

    // done on the 16th cycle wins over the timeout
    idx_in = 2'd1; idx_valid = 1'b1;
    tick();
    idx_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("tod_gnt16", 32'(gnt_oh), 32'h2);
    done = 4'b0010;
    tick();
    done = '0;
    chk("tod_gnt", 32'(gnt_oh), 32'h0);
    chk("tod_no_to", 32'(timeout), 32'h0);
    tick();

    // Wrong done bit is ignored
    idx_in = 2'd3; idx_valid = 1'b1;
    tick();
    idx_valid = 1'b0;
    done = 4'b0001;
    tick();
    done = '0;
    chk("wrong_done", 32'(gnt_oh), 32'h8);
    done = 4'b1000;
    tick();
    done = '0;
    tick();

    // Illegal index on the N=5 build
    idx_in5 = 3'd7; idx_valid5 = 1'b1;
    tick();
    chk("ill_err", 32'(err_idx5), 32'h1);
    chk("ill_gnt", 32'(gnt_oh5), 32'h0);
    chk("ill_ready", 32'(idx_ready5), 32'h1);
    idx_in5 = 3'd4;
    tick();
    idx_valid5 = 1'b0;
    chk("ill_err_end", 32'(err_idx5), 32'h0);
    chk("ill_next", 32'(gnt_oh5), 32'h10);
    done5 = 5'b10000;
    tick();
    done5 = '0;
    tick();

    // Back-to-back grants, done mirroring the grant
    idx_in = 2'd0; idx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b2b_gnt", 32'(gnt_oh), 32'(1 << k));
      chk("b2b_onehot", 32'($countones(gnt_oh)), 32'd1);
      done = gnt_oh;
      idx_in = 2'(k + 1);
      if (k == 3) idx_valid = 1'b0;
      tick();
      done = '0;
      chk("b2b_gap", 32'(gnt_oh), 32'h0);
      tick();
      chk("b2b_ready", 32'(idx_ready), 32'h1);
    end

    // Reset in the 4th grant cycle, then a full-length hold
    idx_in = 2'd0; idx_valid = 1'b1;
    tick();
    idx_valid = 1'b0;
    tick(); tick(); tick();
    chk("rmg_pre", 32'(gnt_oh), 32'h1);
    rst = 1'b1;
    tick();
    chk("rmg_gnt", 32'(gnt_oh), 32'h0);
    tick(); tick();
    rst = 1'b0;
    chk("rmg_busy", 32'(busy), 32'h0);
    chk("rmg_to", 32'(timeout), 32'h0);
    chk("rmg_err", 32'(err_idx), 32'h0);
    chk("rmg_ready", 32'(idx_ready), 32'h1);
    idx_in = 2'd0; idx_valid = 1'b1;
    tick();
    idx_valid = 1'b0;
    count_grant(4'b0001, cyc);
    chk("rmg_full_len", 32'(cyc), 32'd16);
    chk("rmg_full_to", 32'(timeout), 32'h1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
